// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Byte-stream initiator for the native valid/ready memory bus. Decodes command
//   frames arriving on the rx byte stream, performs one single-word read or
//   write on the bus, and returns a status byte (plus read data) on the tx
//   byte stream. Lets a host load memory and poke peripherals without the CPU.
//
//   Frame: CMD, ADDR0..ADDR3 (little endian), DATA0..DATA3 (writes only).
//     CMD 8'h00        read word
//     CMD 8'b1000_wwww write word, byte enables wwww (wwww = 0 is bad)
//     anything else    bad command, answered with 8'h02, no further bytes eaten
//   Response: 8'h00 (+4 read data bytes, LSB first), 8'h01 timeout, 8'h02 bad cmd.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready command byte stream in
//   tx_data/tx_valid/tx_ready response byte stream out
//   mem_valid/mem_ready       bus request / completion
//   mem_addr/mem_wdata        word address ([1:0] = 0) / write data
//   mem_wstrb                 byte enables, 0 = read
//   mem_rdata                 read data, sampled in the mem_ready cycle
//   busy                      high whenever not waiting for a command byte
module mem_bus_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  // Timeout counter is at least one bit wide so TIMEOUT = 0 (wait forever) still elaborates.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TO_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  state_t        state_r;
  logic [1:0]    byte_cnt_r;
  logic          is_write_r;
  logic [TW-1:0] to_cnt_r;
  logic [31:0]   rdata_r;      // read data, shifted out one byte per tx transfer
  logic [2:0]    resp_left_r;  // response bytes still to send after the current one
  logic          rx_ready_r;
  logic [7:0]    tx_data_r;
  logic          tx_valid_r;
  logic          mem_valid_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic [3:0]    mem_wstrb_r;
  logic          busy_r;

  // A write command is 1000_wwww with at least one byte enabled.
  function automatic logic is_write_cmd(input logic [7:0] cmd);
    return (cmd[7:4] == 4'b1000) && (cmd[3:0] != 4'b0000);
  endfunction

  assign rx_ready  = rx_ready_r;
  assign tx_data   = tx_data_r;
  assign tx_valid  = tx_valid_r;
  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;
  assign busy      = busy_r;

  // Frame decoder, bus sequencer and response generator with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_CMD;
      byte_cnt_r  <= 2'd0;
      is_write_r  <= 1'b0;
      to_cnt_r    <= {TW{1'b0}};
      rdata_r     <= 32'h0000_0000;
      resp_left_r <= 3'd0;
      rx_ready_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      tx_valid_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wstrb_r <= 4'h0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_CMD: begin
          // rx_ready is (re)asserted here, so it rises one edge after reset release.
          rx_ready_r <= 1'b1;
          if (rx_valid && rx_ready_r) begin
            byte_cnt_r <= 2'd0;
            if (rx_data == 8'h00) begin
              is_write_r  <= 1'b0;
              mem_wstrb_r <= 4'h0;
              mem_wdata_r <= 32'h0000_0000;
              busy_r      <= 1'b1;
              state_r     <= S_ADDR;
            end else if (is_write_cmd(rx_data)) begin
              is_write_r  <= 1'b1;
              mem_wstrb_r <= rx_data[3:0];
              busy_r      <= 1'b1;
              state_r     <= S_ADDR;
            end else begin
              // Bad command: answer at once, consume nothing more.
              rx_ready_r  <= 1'b0;
              tx_data_r   <= 8'h02;
              tx_valid_r  <= 1'b1;
              resp_left_r <= 3'd0;
              busy_r      <= 1'b1;
              state_r     <= S_RESP;
            end
          end else begin
            state_r <= S_CMD;
          end
        end

        S_ADDR: begin
          if (rx_valid && rx_ready_r) begin
            case (byte_cnt_r)
              2'd0:    mem_addr_r[7:0]   <= {rx_data[7:2], 2'b00};
              2'd1:    mem_addr_r[15:8]  <= rx_data;
              2'd2:    mem_addr_r[23:16] <= rx_data;
              default: mem_addr_r[31:24] <= rx_data;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (is_write_r) begin
                state_r <= S_DATA;
              end else begin
                rx_ready_r  <= 1'b0;
                mem_valid_r <= 1'b1;
                to_cnt_r    <= {TW{1'b0}};
                state_r     <= S_BUS;
              end
            end else begin
              state_r <= S_ADDR;
            end
          end else begin
            state_r <= S_ADDR;
          end
        end

        S_DATA: begin
          if (rx_valid && rx_ready_r) begin
            case (byte_cnt_r)
              2'd0:    mem_wdata_r[7:0]   <= rx_data;
              2'd1:    mem_wdata_r[15:8]  <= rx_data;
              2'd2:    mem_wdata_r[23:16] <= rx_data;
              default: mem_wdata_r[31:24] <= rx_data;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              rx_ready_r  <= 1'b0;
              mem_valid_r <= 1'b1;
              to_cnt_r    <= {TW{1'b0}};
              state_r     <= S_BUS;
            end else begin
              state_r <= S_DATA;
            end
          end else begin
            state_r <= S_DATA;
          end
        end

        S_BUS: begin
          // mem_valid is always high here; mem_ready in the limit cycle still wins.
          if (mem_ready) begin
            mem_valid_r <= 1'b0;
            rdata_r     <= mem_rdata;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b1;
            resp_left_r <= is_write_r ? 3'd0 : 3'd4;
            state_r     <= S_RESP;
          end else if ((TIMEOUT != 0) && (to_cnt_r == TO_LAST)) begin
            mem_valid_r <= 1'b0;
            tx_data_r   <= 8'h01;
            tx_valid_r  <= 1'b1;
            resp_left_r <= 3'd0;
            state_r     <= S_RESP;
          end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end else begin
            to_cnt_r <= to_cnt_r;
          end
        end

        S_RESP: begin
          if (tx_ready) begin
            if (resp_left_r == 3'd0) begin
              tx_valid_r <= 1'b0;
              rx_ready_r <= 1'b1;
              busy_r     <= 1'b0;
              state_r    <= S_CMD;
            end else begin
              tx_data_r   <= rdata_r[7:0];
              rdata_r     <= {8'h00, rdata_r[31:8]};
              resp_left_r <= resp_left_r - 3'd1;
            end
          end else begin
            state_r <= S_RESP;
          end
        end

        default: begin
          state_r     <= S_CMD;
          rx_ready_r  <= 1'b0;
          tx_valid_r  <= 1'b0;
          mem_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_mode = 0;   // 0: ready tied high, 1: one-cycle registered ready, 2: never ready
  int tx_toggle = 0;  // 1: tx_ready toggles every cycle
  logic clr_req = 1'b0;

  // Monitor state
  logic [7:0]  txq[$];
  int          mv_cnt, mv_first, tx_first, unstable, stall_bad, rx_bad;
  logic [31:0] mv_addr, mv_wdata;
  logic [3:0]  mv_wstrb;
  logic [7:0]  held;
  logic        held_v;

  mem_bus_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder
  always @(posedge clk) begin
    case (rsp_mode)
      0:       mem_ready <= 1'b1;
      1:       mem_ready <= mem_valid && !mem_ready;
      default: mem_ready <= 1'b0;
    endcase
  end

  // Tx sink
  always @(posedge clk) tx_ready <= (tx_toggle != 0) ? ~tx_ready : 1'b1;

  // Bus and tx stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (clr_req) begin
      mv_cnt <= 0; mv_first <= -1; tx_first <= -1;
      unstable <= 0; stall_bad <= 0; rx_bad <= 0; held_v <= 1'b0;
      txq.delete();
    end else if (!rst) begin
      if (mem_valid) begin
        if (mv_cnt == 0) begin
          mv_first <= cyc; mv_addr <= mem_addr; mv_wdata <= mem_wdata; mv_wstrb <= mem_wstrb;
        end else if (mem_addr !== mv_addr || mem_wdata !== mv_wdata || mem_wstrb !== mv_wstrb) begin
          unstable <= unstable + 1;
        end
        mv_cnt <= mv_cnt + 1;
      end
      if (tx_valid) begin
        if (tx_first < 0) tx_first <= cyc;
        if (rx_ready) rx_bad <= rx_bad + 1;
        if (held_v && tx_data !== held) stall_bad <= stall_bad + 1;
        if (tx_ready) txq.push_back(tx_data);
      end
      held_v <= tx_valid && !tx_ready;
      held   <= tx_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    @(posedge clk); #1 clr_req = 1'b1;
    @(posedge clk); #1 clr_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept_wait", 32'(n < 200), 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] wd, input bit wr);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (!(txq.size() >= n && busy === 1'b0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("resp_wait", 32'(k < 400), 32'd1);
  endtask

  // exp holds the response bytes with the first byte in bits [7:0]
  task automatic chk_resp(input string tag, input int n, input logic [39:0] exp);
    chk({tag, "_len"}, 32'(txq.size()), 32'(n));
    for (int i = 0; i < n; i++) chk(tag, {24'h0, txq[i]}, {24'h0, exp[8*i +: 8]});
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mem_rdata = 32'h0000_0000;
    clr_req = 1'b1;
    repeat (3) @(negedge clk);
    clr_req = 1'b0;
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'd0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rx_ready_after_rst", {31'h0, rx_ready}, 32'd1);

    // 1: write with ready tied high
    clr(); rsp_mode = 0;
    send_frame(8'h82, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    wait_done(1);
    chk("wr_mv_cycles", 32'(mv_cnt), 32'd1);
    chk("wr_addr", mv_addr, 32'h0000_1000);
    chk("wr_wdata", mv_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", {28'h0, mv_wstrb}, 32'h2);
    chk("wr_mv_latency", 32'(mv_first - acc_cyc), 32'd1);
    chk("wr_tx_latency", 32'(tx_first - acc_cyc), 32'd2);
    chk_resp("wr_resp", 1, 40'h00);

    // 2: read with registered ready
    clr(); rsp_mode = 1; mem_rdata = 32'h1234_5678;
    send_frame(8'h00, 32'h0000_1004, 32'h0, 1'b0);
    wait_done(5);
    chk("rd_addr", mv_addr, 32'h0000_1004);
    chk("rd_wstrb", {28'h0, mv_wstrb}, 32'h0);
    chk("rd_mv_cycles", 32'(mv_cnt), 32'd2);
    chk("rd_unstable", 32'(unstable), 32'd0);
    chk_resp("rd_resp", 5, 40'h12_34_56_78_00);

    // 3: timeout, then a read that succeeds
    clr(); rsp_mode = 2;
    send_frame(8'h00, 32'h0000_7000, 32'h0, 1'b0);
    wait_done(1);
    chk("to_mv_cycles", 32'(mv_cnt), 32'd8);
    chk("to_addr", mv_addr, 32'h0000_7000);
    chk_resp("to_resp", 1, 40'h01);
    clr(); rsp_mode = 1; mem_rdata = 32'hA5A5_5A5A;
    send_frame(8'h00, 32'h0000_7000, 32'h0, 1'b0);
    wait_done(5);
    chk_resp("after_to_resp", 5, 40'hA5_A5_5A_5A_00);

    // 4: bad command, then the host resyncs with a read
    clr();
    send_byte(8'h40);
    wait_done(1);
    chk("bad_mv_cycles", 32'(mv_cnt), 32'd0);
    chk_resp("bad_resp", 1, 40'h02);
    clr(); mem_rdata = 32'hCAFE_F00D;
    send_frame(8'h00, 32'h0000_2000, 32'h0, 1'b0);
    wait_done(5);
    chk("resync_addr", mv_addr, 32'h0000_2000);
    chk_resp("resync_resp", 5, 40'hCA_FE_F0_0D_00);

    // 5: read under tx backpressure
    clr(); tx_toggle = 1; mem_rdata = 32'h89AB_CDEF;
    send_frame(8'h00, 32'h0000_3008, 32'h0, 1'b0);
    wait_done(5);
    tx_toggle = 0;
    chk_resp("bp_resp", 5, 40'h89_AB_CD_EF_00);
    chk("bp_stall_hold", 32'(stall_bad), 32'd0);
    chk("bp_rx_ready_low", 32'(rx_bad), 32'd0);

    // 6: reset while the bus request is pending
    clr(); rsp_mode = 2;
    send_frame(8'h00, 32'h0000_4000, 32'h0, 1'b0);
    begin
      int k;
      k = 0;
      while (mem_valid !== 1'b1 && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("rst_mv_seen", {31'h0, mem_valid}, 32'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("midrst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_rx_ready", {31'h0, rx_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr(); rsp_mode = 0;
    // ADDR0 low bits are set here and must be dropped from mem_addr
    send_frame(8'h8F, 32'h0000_5007, 32'h1122_3344, 1'b1);
    wait_done(1);
    chk("post_rst_mv_cycles", 32'(mv_cnt), 32'd1);
    chk("post_rst_addr", mv_addr, 32'h0000_5004);
    chk("post_rst_wdata", mv_wdata, 32'h1122_3344);
    chk("post_rst_wstrb", {28'h0, mv_wstrb}, 32'hF);
    chk_resp("post_rst_resp", 1, 40'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
